// File: rtl/seg_scan_display.sv
// 8-digit multiplexed 7-segment viewer for the CPU buses and registers.
// Snapshots are taken once per frame so digits never tear mid-scan.
module seg_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic [7:0]  data_out,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  irout,
  input  logic [7:0]  r0dbus,
  input  logic [7:0]  r1dbus,
  input  logic [7:0]  r2dbus,
  input  logic [7:0]  r3dbus,
  input  logic        zout,
  input  logic [1:0]  disp_mode,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]   BLANK_N  = DW'(BLANK);

  localparam logic [1:0] MODE_BUS  = 2'b00;
  localparam logic [1:0] MODE_OPS  = 2'b01;
  localparam logic [1:0] MODE_REGS = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] reg_sel(input logic [1:0] n, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
    case (n)
      2'd0:    reg_sel = a;
      2'd1:    reg_sel = b;
      2'd2:    reg_sel = c;
      default: reg_sel = d;
    endcase
  endfunction

  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap;
  logic [1:0]    r_snap_mode;
  logic          r_snap_z;

  logic          w_tick, w_frame;
  logic [7:0]    w_bb, w_rs, w_rd;
  logic [31:0]   w_snap_nx;
  logic [3:0]    w_nib;
  logic          w_blank, w_dp_low;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_frame = w_tick && (r_idx == 3'd7);

  // data_out may float when not writing, so it only reaches the mux under write
  assign w_bb = write ? data_out : (read ? data_in : 8'h00);
  assign w_rs = reg_sel(irout[3:2], r0dbus, r1dbus, r2dbus, r3dbus);
  assign w_rd = reg_sel(irout[1:0], r0dbus, r1dbus, r2dbus, r3dbus);

  always_comb begin
    w_snap_nx = {addr, w_bb, irout};
    case (disp_mode)
      MODE_OPS:  w_snap_nx = {w_rd, w_rs, irout, 7'b0, zout};
      MODE_REGS: w_snap_nx = {r0dbus, r1dbus, r2dbus, r3dbus};
      default:   w_snap_nx = {addr, w_bb, irout};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div       <= '0;
      r_idx       <= 3'd0;
      r_snap      <= 32'h0;
      r_snap_mode <= MODE_BUS;
      r_snap_z    <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_idx <= r_idx + 3'd1;
      if (w_frame && !freeze) begin
        r_snap      <= w_snap_nx;
        r_snap_mode <= disp_mode;
        r_snap_z    <= zout;
      end
    end
  end

  assign w_nib    = r_snap[{r_idx, 2'b00} +: 4];
  assign w_blank  = (r_snap_mode == MODE_OFF) || (r_div < BLANK_N);
  assign w_dp_low = ((r_idx == 3'd4) && (r_snap_mode == MODE_BUS)) ||
                    ((r_idx == 3'd0) && r_snap_z);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (w_blank) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << r_idx);
      seg <= hex7(w_nib);
      dp  <= ~w_dp_low;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a 4-cycle slot and 1-cycle blank.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0, data_out = '0, irout = '0;
  logic [7:0]  r0dbus = '0, r1dbus = '0, r2dbus = '0, r3dbus = '0;
  logic        read = 1'b0, write = 1'b0, zout = 1'b0, freeze = 1'b0;
  logic [1:0]  disp_mode = 2'b00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;
  int k = 0;

  seg_scan_display #(.SCAN_DIV(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .read(read), .write(write), .irout(irout), .r0dbus(r0dbus), .r1dbus(r1dbus),
    .r2dbus(r2dbus), .r3dbus(r3dbus), .zout(zout), .disp_mode(disp_mode),
    .freeze(freeze), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] addr;
    logic        rd, wr;
    logic [7:0]  din, dout, ir, r0, r1, r2, r3;
    logic        z;
    logic [31:0] nib;
    logic [7:0]  dpl;   // 1 = dp expected low on that digit
    bit          blank;
  } vec_t;

  vec_t tv[10];

  function automatic logic [6:0] exp_hex(input logic [3:0] n);
    case (n)
      4'h0: exp_hex = 7'h40; 4'h1: exp_hex = 7'h79; 4'h2: exp_hex = 7'h24; 4'h3: exp_hex = 7'h30;
      4'h4: exp_hex = 7'h19; 4'h5: exp_hex = 7'h12; 4'h6: exp_hex = 7'h02; 4'h7: exp_hex = 7'h78;
      4'h8: exp_hex = 7'h00; 4'h9: exp_hex = 7'h10; 4'hA: exp_hex = 7'h08; 4'hB: exp_hex = 7'h03;
      4'hC: exp_hex = 7'h46; 4'hD: exp_hex = 7'h21; 4'hE: exp_hex = 7'h06; default: exp_hex = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  // Outputs seen after edge k were computed from the counter state at k-1.
  task automatic check_cycles(input int n, input logic [31:0] nib, input logic [7:0] dpl,
                              input bit blank, input string name);
    for (int c = 0; c < n; c++) begin
      int d, i;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_nib;
      step();
      d = (k - 1) % 4;
      i = ((k - 1) / 4) % 8;
      e_nib = nib[i*4 +: 4];
      if (blank || d < 1) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = ~(8'b1 << i); e_seg = exp_hex(e_nib); e_dp = ~dpl[i];
      end
      chk({name, ".an"}, an, e_an);
      chk({name, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
      chk({name, ".dp"}, {7'b0, dp}, {7'b0, e_dp});
    end
  endtask

  // Advance through the next snapshot edge, then check the frame it produced.
  task automatic check_frame(input logic [31:0] nib, input logic [7:0] dpl,
                             input bit blank, input string name);
    do step(); while (k % 32 != 0);
    check_cycles(32, nib, dpl, blank, name);
  endtask

  task automatic apply(input vec_t v);
    disp_mode = v.mode; addr = v.addr; read = v.rd; write = v.wr;
    data_in = v.din; data_out = v.dout; irout = v.ir;
    r0dbus = v.r0; r1dbus = v.r1; r2dbus = v.r2; r3dbus = v.r3; zout = v.z;
  endtask

  initial begin
    tv[0] = '{2'b00, 16'h12AB, 1'b0, 1'b1, 8'h00, 8'h5C, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h12AB5C3E, 8'h10, 1'b0};
    tv[1] = '{2'b00, 16'h12AB, 1'b1, 1'b0, 8'h77, 8'h5C, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h12AB773E, 8'h10, 1'b0};
    tv[2] = '{2'b00, 16'h12AB, 1'b0, 1'b0, 8'h77, 8'hFF, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h12AB003E, 8'h10, 1'b0};
    tv[3] = '{2'b00, 16'h12AB, 1'b1, 1'b1, 8'hAA, 8'h55, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h12AB553E, 8'h10, 1'b0};
    tv[4] = '{2'b01, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 8'h00, 8'hF0, 8'h0D, 8'h00, 1'b1, 32'hF00D0901, 8'h01, 1'b0};
    tv[5] = '{2'b01, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h06, 8'h00, 8'hA5, 8'h3C, 8'h00, 1'b0, 32'h3CA50600, 8'h00, 1'b0};
    tv[6] = '{2'b10, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h11223344, 8'h00, 1'b0};
    tv[7] = '{2'b10, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 32'h11223344, 8'h01, 1'b0};
    tv[8] = '{2'b11, 16'h12AB, 1'b0, 1'b1, 8'h00, 8'h5C, 8'h3E, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 32'h00000000, 8'h00, 1'b1};
    tv[9] = '{2'b00, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'h00000000, 8'h11, 1'b0};

    // reset held across edges
    @(negedge clk); @(negedge clk);
    chk("rst.an", an, 8'hFF);
    chk("rst.seg", {1'b0, seg}, 8'h7F);
    chk("rst.dp", {7'b0, dp}, 8'h01);

    rst = 1'b1; k = 0;
    check_cycles(14, 32'h0, 8'h10, 1'b0, "boot");
    // asynchronous reset mid-digit, checked before any clock edge
    #1 rst = 1'b0;
    #1;
    chk("midrst.an", an, 8'hFF);
    chk("midrst.seg", {1'b0, seg}, 8'h7F);
    chk("midrst.dp", {7'b0, dp}, 8'h01);
    @(negedge clk);
    rst = 1'b1; k = 0;
    check_cycles(32, 32'h0, 8'h10, 1'b0, "scan0");

    for (int v = 0; v < 10; v++) begin
      apply(tv[v]);
      check_frame(tv[v].nib, tv[v].dpl, tv[v].blank, $sformatf("vec%0d", v));
    end

    // freeze holds the snapshot while the registers change underneath
    apply(tv[6]);
    check_frame(32'h11223344, 8'h00, 1'b0, "frz.pre");
    freeze = 1'b1;
    r0dbus = 8'h00; r1dbus = 8'h00; r2dbus = 8'h00; r3dbus = 8'h00; zout = 1'b1;
    for (int f = 0; f < 3; f++) check_frame(32'h11223344, 8'h00, 1'b0, "frz.hold");
    freeze = 1'b0;
    check_frame(32'h00000000, 8'h01, 1'b0, "frz.rel");

    // mode change at digit 3 waits for the next frame boundary
    apply(tv[6]);
    check_frame(32'h11223344, 8'h00, 1'b0, "msw.pre");
    check_cycles(14, 32'h11223344, 8'h00, 1'b0, "msw.a");
    disp_mode = 2'b11; zout = 1'b1;
    check_cycles(18, 32'h11223344, 8'h00, 1'b0, "msw.b");
    check_cycles(64, 32'h0, 8'h00, 1'b1, "msw.off");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
